conv_layer_sched: RTL and testbench

- Sequencer that drives the conv datapath through all input channels of one layer.
- Per channel it: presents config, pulses the conv trigger, accepts each output pixel (valid/done + addr), writes it into the output buffer, and returns the save_done acknowledge.
- Sits between the top-level layer controller and the conv block; checks pixel count per channel and watchdogs a stalled datapath.

---
 rtl/conv_layer_sched.sv | 206 ++++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// ---------------------------------------------------------------------------
// conv_layer_sched
//
// Walks the convolution datapath through every input channel of one layer.
// For each channel it presents the latched configuration, pulses
// conv_trigger, accepts each output pixel, writes it into the output buffer
// and returns conv_save_done once the buffer write has had WR_LAT cycles to
// land. The pixel count per channel is checked against (in_h-2)*(in_w-2),
// and a watchdog aborts the layer if the datapath stops producing pixels.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle layer request (ignored unless idle)
//   cfg_layer/chans/    layer configuration, latched on accepted start
//   cfg_in_w/cfg_in_h
//   busy, layer_done    layer in progress / one-cycle end-of-layer pulse
//   err_count           sticky: a channel produced the wrong pixel count
//   err_timeout         sticky: watchdog expired waiting for a pixel
//   conv_trigger        one-cycle channel start pulse to the conv block
//   conv_save_done      one-cycle pixel acknowledge to the conv block
//   conv_chan/layer/    current channel and latched configuration
//   conv_in_w/in_h
//   conv_valid/done     pixel ready (done marks the last pixel of a channel)
//   conv_pixel/addr     pixel value and its index within the channel
//   ob_wr_en/addr/data  output buffer write port, addr = {chan, pixel addr}
// ---------------------------------------------------------------------------
module conv_layer_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 8,
    parameter int CHAN_W     = 4,
    parameter int WR_LAT     = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_layer,
    input  logic [CHAN_W:0]          cfg_chans,
    input  logic [4:0]               cfg_in_w,
    input  logic [4:0]               cfg_in_h,
    output logic                     busy,
    output logic                     layer_done,
    output logic                     err_count,
    output logic                     err_timeout,
    output logic                     conv_trigger,
    output logic                     conv_save_done,
    output logic [CHAN_W-1:0]        conv_chan,
    output logic                     conv_layer,
    output logic [4:0]               conv_in_w,
    output logic [4:0]               conv_in_h,
    input  logic                     conv_valid,
    input  logic                     conv_done,
    input  logic [DATA_WIDTH-1:0]    conv_pixel,
    input  logic [ADDR_W-1:0]        conv_addr,
    output logic                     ob_wr_en,
    output logic [CHAN_W+ADDR_W-1:0] ob_wr_addr,
    output logic [DATA_WIDTH-1:0]    ob_wr_data
);

    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(WR_LAT + 1);
    localparam logic [CHAN_W:0] CHANS_ONE = 1;

    typedef enum logic [3:0] {
        IDLE, TRIG, WAIT, WRITE, HOLD, ACK, SETTLE, NEXT, FIN
    } state_t;

    state_t state, next_state;

    logic [CHAN_W:0]       chans_lat;
    logic [9:0]            exp_cnt;
    logic [9:0]            pix_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [ADDR_W-1:0]     addr_lat;
    logic                  last_lat;

    logic pix_in;
    logic wd_expired;
    logic hold_last;
    logic last_chan;

    // done and valid are both "a pixel is here"; done only adds the last flag,
    // which is how done wins when both are high.
    assign pix_in     = conv_valid | conv_done;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign hold_last  = (hold_cnt == HOLD_W'(WR_LAT - 2));
    assign last_chan  = ({1'b0, conv_chan} == chans_lat - CHANS_ONE);

    assign ob_wr_addr = {conv_chan, addr_lat};

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default before the case; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (start) next_state = (cfg_chans == '0) ? FIN : TRIG;
            TRIG:   next_state = WAIT;
            WAIT: begin
                if (pix_in)          next_state = WRITE;
                else if (wd_expired) next_state = FIN;
            end
            // With a single-cycle buffer write the acknowledge follows directly.
            WRITE:  next_state = (WR_LAT == 1) ? ACK : HOLD;
            HOLD:   if (hold_last) next_state = ACK;
            ACK:    next_state = last_lat ? NEXT : SETTLE;
            SETTLE: next_state = WAIT;
            NEXT:   next_state = last_chan ? FIN : TRIG;
            FIN:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: all strobes are pure functions of the current state.
    always_comb begin
        busy           = 1'b0;
        layer_done     = 1'b0;
        conv_trigger   = 1'b0;
        conv_save_done = 1'b0;
        ob_wr_en       = 1'b0;
        unique case (state)
            IDLE:    ;
            TRIG:    begin busy = 1'b1; conv_trigger = 1'b1; end
            WRITE:   begin busy = 1'b1; ob_wr_en = 1'b1; end
            // The last pixel of a channel is not acknowledged; the next
            // trigger restarts the conv block instead.
            ACK:     begin busy = 1'b1; conv_save_done = ~last_lat; end
            FIN:     layer_done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Datapath: configuration latch, counters, pixel capture, sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            chans_lat   <= '0;
            conv_layer  <= 1'b0;
            conv_in_w   <= '0;
            conv_in_h   <= '0;
            conv_chan   <= '0;
            exp_cnt     <= '0;
            pix_cnt     <= '0;
            wd_cnt      <= '0;
            hold_cnt    <= '0;
            addr_lat    <= '0;
            ob_wr_data  <= '0;
            last_lat    <= 1'b0;
            err_count   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        chans_lat   <= cfg_chans;
                        conv_layer  <= cfg_layer;
                        conv_in_w   <= cfg_in_w;
                        conv_in_h   <= cfg_in_h;
                        conv_chan   <= '0;
                        // Valid-convolution output size, evaluated in 10 bits.
                        exp_cnt     <= ({5'd0, cfg_in_h} - 10'd2) *
                                       ({5'd0, cfg_in_w} - 10'd2);
                        err_count   <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                TRIG: begin
                    pix_cnt <= '0;
                    wd_cnt  <= '0;
                end
                WAIT: begin
                    if (pix_in) begin
                        ob_wr_data <= conv_pixel;
                        addr_lat   <= conv_addr;
                        last_lat   <= conv_done;
                        pix_cnt    <= pix_cnt + 10'd1;
                    end else if (wd_expired) begin
                        err_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                WRITE:  hold_cnt <= '0;
                HOLD:   hold_cnt <= hold_cnt + HOLD_W'(1);
                // The watchdog restarts for each pixel once the acknowledged
                // valid has had a cycle to drop.
                SETTLE: wd_cnt <= '0;
                NEXT: begin
                    if (pix_cnt != exp_cnt) err_count <= 1'b1;
                    if (!last_chan) conv_chan <= conv_chan + CHAN_W'(1);
                end
                FIN:    conv_chan <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// ---------------------------------------------------------------------------
// Testbench for conv_layer_sched. A behavioural conv model emits randomized
// pixels per channel according to a per-channel pixel plan; every emitted
// pixel is recorded as the expected buffer write. Observed writes, acks,
// triggers and layer_done pulses are logged and compared per scenario.
// ---------------------------------------------------------------------------
module tb_conv_layer_sched;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_W     = 8;
    localparam int CHAN_W     = 4;
    localparam int WR_LAT     = 2;
    localparam int TIMEOUT    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cfg_layer = 1'b0;
    logic [CHAN_W:0] cfg_chans = '0;
    logic [4:0] cfg_in_w = '0;
    logic [4:0] cfg_in_h = '0;
    logic conv_valid = 1'b0;
    logic conv_done = 1'b0;
    logic [DATA_WIDTH-1:0] conv_pixel = '0;
    logic [ADDR_W-1:0] conv_addr = '0;

    logic busy, layer_done, err_count, err_timeout, conv_trigger, conv_save_done;
    logic [CHAN_W-1:0] conv_chan;
    logic conv_layer;
    logic [4:0] conv_in_w, conv_in_h;
    logic ob_wr_en;
    logic [CHAN_W+ADDR_W-1:0] ob_wr_addr;
    logic [DATA_WIDTH-1:0] ob_wr_data;

    always #5 clk = ~clk;

    conv_layer_sched #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W), .CHAN_W(CHAN_W),
        .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_layer(cfg_layer),
        .cfg_chans(cfg_chans), .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h),
        .busy(busy), .layer_done(layer_done), .err_count(err_count),
        .err_timeout(err_timeout), .conv_trigger(conv_trigger),
        .conv_save_done(conv_save_done), .conv_chan(conv_chan),
        .conv_layer(conv_layer), .conv_in_w(conv_in_w), .conv_in_h(conv_in_h),
        .conv_valid(conv_valid), .conv_done(conv_done), .conv_pixel(conv_pixel),
        .conv_addr(conv_addr), .ob_wr_en(ob_wr_en), .ob_wr_addr(ob_wr_addr),
        .ob_wr_data(ob_wr_data)
    );

    logic [41:0] outs;
    assign outs = {busy, layer_done, err_count, err_timeout, conv_trigger,
                   conv_save_done, conv_chan, conv_layer, conv_in_w, conv_in_h,
                   ob_wr_en, ob_wr_addr, ob_wr_data};

    typedef struct {
        int        cyc;
        logic [11:0] addr;
        logic [7:0]  data;
        bit        last;
    } wr_t;

    // Scenario setup
    int plan[$];
    bit respond;
    bit spam_start;
    int rst_at;
    logic exp_layer;
    logic [CHAN_W:0] exp_chans;
    logic [4:0] exp_w, exp_h;

    // Observations and model output
    wr_t exp_q[$];
    wr_t wr_log[$];
    int sd_log[$];
    int trig_cyc[$];
    int trig_chan[$];
    int done_cyc[$];
    int cfg_bad;
    bit run_expired;
    logic [41:0] outs_after_rst;
    int cyc = 0;
    int start_cyc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Number of observed writes that differ from the emitted pixel stream.
    function automatic int wr_errs();
        int e;
        e = 0;
        if (wr_log.size() != exp_q.size()) e++;
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
            if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) e++;
        return e;
    endfunction

    // Every non-last pixel must be acknowledged WR_LAT cycles after its write.
    function automatic int sd_errs();
        int e;
        int exp_sd[$];
        e = 0;
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
            if (!exp_q[i].last) exp_sd.push_back(wr_log[i].cyc + WR_LAT);
        if (exp_sd.size() != sd_log.size()) e++;
        for (int i = 0; i < exp_sd.size() && i < sd_log.size(); i++)
            if (exp_sd[i] != sd_log[i]) e++;
        return e;
    endfunction

    // Issues start with the exp_* config, then plays the conv block until
    // layer_done, a planted reset, or the cycle budget runs out.
    task automatic conv_run(input int budget);
        int ch, idx, gap, rst_phase;
        bit active, presenting, cur_last;
        ch = 0; idx = 0; gap = 0; rst_phase = 0;
        active = 0; presenting = 0; cur_last = 0;
        wr_log.delete(); exp_q.delete(); sd_log.delete();
        trig_cyc.delete(); trig_chan.delete(); done_cyc.delete();
        cfg_bad = 0;
        run_expired = 1;
        start_cyc = cyc;
        cfg_layer = exp_layer; cfg_chans = exp_chans;
        cfg_in_w = exp_w; cfg_in_h = exp_h;
        start = 1'b1;
        for (int k = 0; k < budget; k++) begin
            tick();
            start = 1'b0;
            cfg_layer = exp_layer; cfg_chans = exp_chans;
            cfg_in_w = exp_w; cfg_in_h = exp_h;

            if (conv_trigger) begin
                trig_cyc.push_back(cyc);
                trig_chan.push_back(int'(conv_chan));
                ch = trig_cyc.size() - 1;
                active = respond && (ch < plan.size());
                idx = 0; presenting = 0;
                gap = $urandom_range(0, 2);
            end
            if (ob_wr_en) wr_log.push_back('{cyc, ob_wr_addr, ob_wr_data, 1'b0});
            if (conv_save_done) sd_log.push_back(cyc);
            if (layer_done) done_cyc.push_back(cyc);
            if (busy && (conv_layer !== exp_layer || conv_in_w !== exp_w || conv_in_h !== exp_h))
                cfg_bad++;

            if (layer_done) begin
                run_expired = 0;
                break;
            end
            if (rst_phase == 2) begin
                outs_after_rst = outs;
                rst = 1'b0;
                run_expired = 0;
                break;
            end
            if (rst_phase == 1) begin
                rst = 1'b1;
                rst_phase = 2;
            end
            if (ob_wr_en && rst_at >= 0 && wr_log.size() == rst_at + 1) rst_phase = 1;

            if (spam_start && busy && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                cfg_layer = ~exp_layer;
                cfg_chans = 5'($urandom);
                cfg_in_w = 5'($urandom);
                cfg_in_h = 5'($urandom);
            end

            if (active) begin
                if (presenting) begin
                    if (!cur_last && conv_save_done) begin
                        presenting = 0; conv_valid = 1'b0;
                        idx++;
                        gap = $urandom_range(0, 2);
                    end else if (cur_last && ob_wr_en) begin
                        presenting = 0; active = 0;
                        conv_valid = 1'b0; conv_done = 1'b0;
                    end
                end
                if (active && !presenting) begin
                    if (gap > 0) begin
                        gap--;
                    end else begin
                        cur_last = (idx == plan[ch] - 1);
                        conv_addr = idx[7:0];
                        conv_pixel = 8'($urandom);
                        // On the last pixel valid may also be high; done wins.
                        conv_valid = cur_last ? 1'($urandom_range(0, 1)) : 1'b1;
                        conv_done = cur_last;
                        exp_q.push_back('{0, {ch[3:0], idx[7:0]}, conv_pixel, cur_last});
                        presenting = 1;
                    end
                end
            end
        end
        conv_valid = 1'b0;
        conv_done = 1'b0;
        start = 1'b0;
    endtask

    task automatic set_cfg(input logic l, input int chans, input int w, input int h);
        exp_layer = l; exp_chans = 5'(chans); exp_w = 5'(w); exp_h = 5'(h);
        respond = 1; spam_start = 0; rst_at = -1;
        plan.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL reset_outs: got %h expected 0", outs); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL reset_release_outs: got %h expected 0", outs); end
    endtask

    task automatic test_basic();
        set_cfg(1'b0, 1, 15, 16);
        plan.push_back(182);
        conv_run(4000);
        n_cmp++;
        if (run_expired !== 1'b0) begin n_bad++; $display("FAIL basic_expired: got %0d expected 0", run_expired); end
        n_cmp++;
        if (trig_cyc.size() != 1 || trig_cyc[0] != start_cyc + 1) begin
            n_bad++; $display("FAIL basic_trigger: got %0d triggers expected 1 at start+1", trig_cyc.size());
        end
        n_cmp++;
        if (wr_log.size() != 182) begin n_bad++; $display("FAIL basic_write_count: got %0d expected 182", wr_log.size()); end
        n_cmp++;
        if (wr_errs() != 0) begin n_bad++; $display("FAIL basic_write_content: got %0d bad expected 0", wr_errs()); end
        n_cmp++;
        if (sd_log.size() != 181) begin n_bad++; $display("FAIL basic_ack_count: got %0d expected 181", sd_log.size()); end
        n_cmp++;
        if (sd_errs() != 0) begin n_bad++; $display("FAIL basic_ack_latency: got %0d bad expected 0", sd_errs()); end
        n_cmp++;
        if (wr_log.size() == 0 || done_cyc.size() != 1 ||
            done_cyc[0] - wr_log[wr_log.size()-1].cyc != WR_LAT + 2) begin
            n_bad++; $display("FAIL basic_layer_done: got %0d pulses expected 1 at last write+%0d", done_cyc.size(), WR_LAT + 2);
        end
        n_cmp++;
        if ({err_count, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL basic_errors: got %b expected 00", {err_count, err_timeout}); end
        n_cmp++;
        if (cfg_bad != 0) begin n_bad++; $display("FAIL basic_cfg_stable: got %0d bad cycles expected 0", cfg_bad); end
        tick();
        n_cmp++;
        if ({busy, layer_done} !== 2'b00) begin n_bad++; $display("FAIL basic_idle: got %b expected 00", {busy, layer_done}); end
    endtask

    task automatic test_multi_chan();
        int bad;
        set_cfg(1'b1, 3, 5, 5);
        plan = '{9, 9, 9};
        spam_start = 1;
        conv_run(2000);
        bad = 0;
        for (int i = 0; i < trig_chan.size(); i++) if (trig_chan[i] != i) bad++;
        n_cmp++;
        if (trig_chan.size() != 3 || bad != 0) begin
            n_bad++; $display("FAIL multi_triggers: got %0d (%0d wrong chan) expected 3", trig_chan.size(), bad);
        end
        n_cmp++;
        if (wr_log.size() != 27 || wr_errs() != 0) begin
            n_bad++; $display("FAIL multi_writes: got %0d writes, %0d bad expected 27, 0", wr_log.size(), wr_errs());
        end
        n_cmp++;
        if (sd_errs() != 0) begin n_bad++; $display("FAIL multi_ack: got %0d bad expected 0", sd_errs()); end
        n_cmp++;
        if (wr_log.size() == 0 || done_cyc.size() != 1 ||
            done_cyc[0] - wr_log[wr_log.size()-1].cyc != WR_LAT + 2) begin
            n_bad++; $display("FAIL multi_layer_done: got %0d pulses expected 1 after last write", done_cyc.size());
        end
        n_cmp++;
        if (cfg_bad != 0) begin n_bad++; $display("FAIL multi_cfg_ignored_start: got %0d bad cycles expected 0", cfg_bad); end
        n_cmp++;
        if ({err_count, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL multi_errors: got %b expected 00", {err_count, err_timeout}); end
        tick();
    endtask

    task automatic test_count_err();
        set_cfg(1'b0, 2, 5, 5);
        plan = '{8, 9};
        conv_run(2000);
        n_cmp++;
        if (trig_cyc.size() != 2 || wr_log.size() != 17 || wr_errs() != 0) begin
            n_bad++; $display("FAIL cnt_err_run: got %0d triggers %0d writes expected 2, 17", trig_cyc.size(), wr_log.size());
        end
        n_cmp++;
        if ({err_count, err_timeout, layer_done} !== 3'b101) begin
            n_bad++; $display("FAIL cnt_err_flags: got %b expected 101", {err_count, err_timeout, layer_done});
        end
        tick();
        // A zero-channel layer clears the sticky flag and finishes at once.
        set_cfg(1'b1, 0, 7, 9);
        conv_run(10);
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != start_cyc + 1 || trig_cyc.size() != 0) begin
            n_bad++; $display("FAIL zero_chans: got %0d done %0d triggers expected done at start+1, 0 triggers", done_cyc.size(), trig_cyc.size());
        end
        n_cmp++;
        if ({err_count, busy} !== 2'b00) begin n_bad++; $display("FAIL cnt_err_cleared: got %b expected 00", {err_count, busy}); end
        tick();
    endtask

    task automatic test_timeout();
        set_cfg(1'($urandom), 2, $urandom_range(5, 31), $urandom_range(5, 31));
        respond = 0;
        conv_run(500);
        n_cmp++;
        if (run_expired !== 1'b0) begin n_bad++; $display("FAIL timeout_expired: got %0d expected 0", run_expired); end
        n_cmp++;
        if (trig_cyc.size() != 1 || done_cyc.size() != 1 || done_cyc[0] - trig_cyc[0] != TIMEOUT + 1) begin
            n_bad++; $display("FAIL timeout_latency: got %0d triggers %0d done expected done at trigger+%0d", trig_cyc.size(), done_cyc.size(), TIMEOUT + 1);
        end
        n_cmp++;
        if ({err_timeout, err_count, busy} !== 3'b100 || wr_log.size() != 0) begin
            n_bad++; $display("FAIL timeout_flags: got %b with %0d writes expected 100 and 0", {err_timeout, err_count, busy}, wr_log.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            int expc;
            bit exp_err;
            set_cfg(1'($urandom), $urandom_range(1, 3), $urandom_range(5, 8), $urandom_range(5, 8));
            spam_start = 1;
            expc = (int'(exp_h) - 2) * (int'(exp_w) - 2);
            exp_err = 0;
            for (int c = 0; c < int'(exp_chans); c++) begin
                int p;
                p = expc;
                if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 1) ? expc + 1 : expc - 1;
                if (p != expc) exp_err = 1;
                plan.push_back(p);
            end
            conv_run(3000);
            n_cmp++;
            if (wr_errs() != 0 || sd_errs() != 0 || trig_cyc.size() != plan.size()) begin
                n_bad++; $display("FAIL b2b_run%0d: got %0d write/%0d ack errors, %0d triggers expected 0/0/%0d", n, wr_errs(), sd_errs(), trig_cyc.size(), plan.size());
            end
            n_cmp++;
            if ({err_count, err_timeout, layer_done} !== {exp_err, 2'b01}) begin
                n_bad++; $display("FAIL b2b_flags%0d: got %b expected %b", n, {err_count, err_timeout, layer_done}, {exp_err, 2'b01});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(1'b1, 2, 5, 5);
        plan = '{9, 9};
        rst_at = 5;
        conv_run(1000);
        n_cmp++;
        if (outs_after_rst !== '0) begin n_bad++; $display("FAIL rst_mid_outs: got %h expected 0", outs_after_rst); end
        n_cmp++;
        if (wr_log.size() != 6 || sd_log.size() != 5) begin
            n_bad++; $display("FAIL rst_mid_counts: got %0d writes %0d acks expected 6, 5", wr_log.size(), sd_log.size());
        end
        tick();
        set_cfg(1'b0, 2, 5, 5);
        plan = '{9, 9};
        conv_run(2000);
        n_cmp++;
        if (wr_log.size() != 18 || wr_errs() != 0 || trig_chan.size() != 2 || trig_chan[0] != 0) begin
            n_bad++; $display("FAIL rst_mid_rerun: got %0d writes %0d bad expected 18, 0 from channel 0", wr_log.size(), wr_errs());
        end
        n_cmp++;
        if ({err_count, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_errors: got %b expected 00", {err_count, err_timeout}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_chan();
        test_count_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no summary expected finish within 500000 ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule
